id_ex_pipeline: RTL and testbench
=================================

// Module: id_ex_pipeline
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Captures register file read data,
//  decoded fields and control bits at the end of ID and presents them to EX. Inserts a single bubble and
//  raises Hazard_Stall when the instruction in EX is a load whose destination is a source of the ID instruction.
// PARAMETERS
//  DATA_W  32  datapath width (Rs/Rt data, immediate, PC+4)
//  REG_AW  5   register index width
//  ALUOP_W 4   ALU operation code width
// PORTS
//  Clk                in   1        clock; all state updates on posedge
//  Rst                in   1        synchronous active-high reset
//  Stall              in   1        freeze EX (downstream memory stall): hold all outputs
//  Flush              in   1        branch/jump squash: load a bubble
//  Rs_data_ID/Rt_data_ID in DATA_W  register file read data (driven on negedge; sampled here on posedge)
//  Rs_ID/Rt_ID/Rd_ID  in   REG_AW   source/destination indices from decode
//  Imm_ID             in   DATA_W   sign-extended immediate
//  PC_plus4_ID        in   DATA_W   PC+4 of ID instruction
//  RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID,
//  Load_Byte_control_ID, Store_Byte_control_ID  in 1 each  decoded control bits
//  ALUOp_ID           in   ALUOP_W  ALU operation
//  *_EX (one per *_ID input above) out same width  registered copies for EX
//  RegWr_EX           out  REG_AW   resolved destination: RegDst_EX ? Rd_EX : Rt_EX
//  Hazard_Stall       out  1        combinational; freezes PC and IF/ID for one cycle
// BEHAVIOUR
//  - Reset (Rst=1 at posedge): every *_EX register <= 0; RegWr_EX therefore 0; Hazard_Stall follows from 0s.
//  - hazard = MemRead_EX && Rt_EX!=0 && (Rt_EX==Rs_ID || Rt_EX==Rt_ID). Hazard_Stall = hazard && !Flush && !Stall.
//  - Per posedge, priority: Rst > Flush (bubble) > Stall (hold) > hazard (bubble) > load all *_ID into *_EX.
//  - Bubble: all control *_EX bits and ALUOp_EX <= 0; data/index/imm/PC fields <= 0 (deterministic NOP).
//  - Latency: 1 cycle ID->EX. Hazard bubble lasts exactly 1 cycle: next cycle MemRead_EX=0 so hazard drops
//    and the held ID instruction loads normally (register file now returns the written-back value).
//  - Flush and hazard in same cycle: single bubble, Hazard_Stall=0 (squashed instruction need not be held).
//  - Stall and Flush together: Flush wins (bubble loaded).
//  - Load into $zero (Rt_EX=0) never raises hazard. Rs_ID==Rt_ID==Rt_EX counts as one hazard.
//  - Rst asserted mid-stall/bubble: outputs zero next edge, no residual Hazard_Stall.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined: adds out Bubble_count[31:0]; increments on every posedge that loads a bubble
//    (Flush or hazard, not Rst); saturates at 32'hFFFF_FFFF; cleared by Rst; held during Stall.
//  Not defined: no counter, port absent; all other behaviour identical.
// STRUCTURE
//  - Shared package mips_pkg: ALUOP_* encodings, REG_ZERO=5'd0, DATA_W/REG_AW constants, id_ex_ctrl_t
//    struct bundling the control bits, CTRL_BUBBLE constant (all zeros).
//  - One sub-module: load_use_detector (pure combinational hazard compare); register bank in top.
// TESTING
//  1 Reset: Rst=1 one edge with all *_ID=1s -> all *_EX=0, Hazard_Stall=0.
//  2 Pass-through: Rs_data_ID=32'h0A12, Rt_ID=8, Rd_ID=19, RegDst_ID=1, RegWrite_ID=1 -> next cycle
//    Rs_data_EX=32'h0A12, RegWr_EX=19, RegWrite_EX=1.
//  3 Load-use: EX holds lw MemRead_EX=1 Rt_EX=8; ID Rs_ID=8 -> Hazard_Stall=1, next edge all controls 0;
//    following edge ID instruction loaded, Hazard_Stall=0.
//  4 Zero dest: MemRead_EX=1 Rt_EX=0, Rs_ID=0 -> Hazard_Stall=0, normal load.
//  5 Stall/Flush: Stall=1 two cycles -> *_EX unchanged; then Stall=1,Flush=1 -> bubble loaded.
//  6 (ID_EX_PERF_CNT_EN) one hazard + two flushes + one Stall cycle -> Bubble_count=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU op encodings and the ID/EX control bundle.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = 4'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 4'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
    logic load_byte;
    logic store_byte;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = id_ex_ctrl_t'(8'd0);

endpackage

// File: rtl/id_ex_pipeline_load_use_detector.sv
// Combinational load-use compare between the load in EX and the sources of the ID instruction.
module load_use_detector
  import mips_pkg::*;
#(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  output logic              hazard
);

  // A load into $zero produces nothing to wait for, so it never stalls.
  always_comb begin
    hazard = 1'b0;
    if (mem_read_ex && (rt_ex != REG_AW'(REG_ZERO)) && ((rt_ex == rs_id) || (rt_ex == rt_id))) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipeline
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [DATA_W-1:0]  Rs_data_ID,
  input  logic [DATA_W-1:0]  Rt_data_ID,
  input  logic [REG_AW-1:0]  Rs_ID,
  input  logic [REG_AW-1:0]  Rt_ID,
  input  logic [REG_AW-1:0]  Rd_ID,
  input  logic [DATA_W-1:0]  Imm_ID,
  input  logic [DATA_W-1:0]  PC_plus4_ID,
  input  logic               RegWrite_ID,
  input  logic               MemRead_ID,
  input  logic               MemWrite_ID,
  input  logic               MemToReg_ID,
  input  logic               ALUSrc_ID,
  input  logic               RegDst_ID,
  input  logic               Load_Byte_control_ID,
  input  logic               Store_Byte_control_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  output logic [DATA_W-1:0]  Rs_data_EX,
  output logic [DATA_W-1:0]  Rt_data_EX,
  output logic [REG_AW-1:0]  Rs_EX,
  output logic [REG_AW-1:0]  Rt_EX,
  output logic [REG_AW-1:0]  Rd_EX,
  output logic [DATA_W-1:0]  Imm_EX,
  output logic [DATA_W-1:0]  PC_plus4_EX,
  output logic               RegWrite_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic               MemToReg_EX,
  output logic               ALUSrc_EX,
  output logic               RegDst_EX,
  output logic               Load_Byte_control_EX,
  output logic               Store_Byte_control_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic [REG_AW-1:0]  RegWr_EX,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        Bubble_count,
`endif
  output logic               Hazard_Stall
);

  id_ex_ctrl_t ctrl_id_s;
  id_ex_ctrl_t ctrl_ex_r;
  logic        hazard_s;
  logic        bubble_s;
  logic        load_s;

  assign ctrl_id_s = '{reg_write: RegWrite_ID, mem_read: MemRead_ID, mem_write: MemWrite_ID,
                       mem_to_reg: MemToReg_ID, alu_src: ALUSrc_ID, reg_dst: RegDst_ID,
                       load_byte: Load_Byte_control_ID, store_byte: Store_Byte_control_ID};

  assign RegWrite_EX           = ctrl_ex_r.reg_write;
  assign MemRead_EX            = ctrl_ex_r.mem_read;
  assign MemWrite_EX           = ctrl_ex_r.mem_write;
  assign MemToReg_EX           = ctrl_ex_r.mem_to_reg;
  assign ALUSrc_EX             = ctrl_ex_r.alu_src;
  assign RegDst_EX             = ctrl_ex_r.reg_dst;
  assign Load_Byte_control_EX  = ctrl_ex_r.load_byte;
  assign Store_Byte_control_EX = ctrl_ex_r.store_byte;

  load_use_detector #(.REG_AW(REG_AW)) u_detect (
    .mem_read_ex (ctrl_ex_r.mem_read),
    .rt_ex       (Rt_EX),
    .rs_id       (Rs_ID),
    .rt_id       (Rt_ID),
    .hazard      (hazard_s)
  );

  // Edge action: Flush beats Stall, Stall beats a hazard bubble; a squashed instruction is never held.
  always_comb begin
    bubble_s     = 1'b0;
    load_s       = 1'b0;
    Hazard_Stall = 1'b0;
    if (Flush) begin
      bubble_s = 1'b1;
    end else if (Stall) begin
      bubble_s = 1'b0;
    end else if (hazard_s) begin
      bubble_s     = 1'b1;
      Hazard_Stall = 1'b1;
    end else begin
      load_s = 1'b1;
    end
  end

  // Destination mux for write-back.
  always_comb begin
    RegWr_EX = Rt_EX;
    if (ctrl_ex_r.reg_dst) begin
      RegWr_EX = Rd_EX;
    end else begin
      RegWr_EX = Rt_EX;
    end
  end

  // Pipeline register bank; a bubble zeroes every field so EX sees a deterministic NOP.
  always_ff @(posedge Clk) begin
    if (Rst || bubble_s) begin
      ctrl_ex_r   <= CTRL_BUBBLE;
      ALUOp_EX    <= {ALUOP_W{1'b0}};
      Rs_data_EX  <= {DATA_W{1'b0}};
      Rt_data_EX  <= {DATA_W{1'b0}};
      Rs_EX       <= {REG_AW{1'b0}};
      Rt_EX       <= {REG_AW{1'b0}};
      Rd_EX       <= {REG_AW{1'b0}};
      Imm_EX      <= {DATA_W{1'b0}};
      PC_plus4_EX <= {DATA_W{1'b0}};
    end else if (load_s) begin
      ctrl_ex_r   <= ctrl_id_s;
      ALUOp_EX    <= ALUOp_ID;
      Rs_data_EX  <= Rs_data_ID;
      Rt_data_EX  <= Rt_data_ID;
      Rs_EX       <= Rs_ID;
      Rt_EX       <= Rt_ID;
      Rd_EX       <= Rd_ID;
      Imm_EX      <= Imm_ID;
      PC_plus4_EX <= PC_plus4_ID;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Saturating count of edges that load a bubble; reset edges do not count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Bubble_count <= 32'd0;
    end else if (bubble_s && (Bubble_count != 32'hFFFF_FFFF)) begin
      Bubble_count <= Bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Directed table-driven bench for id_ex_pipeline plus hand sequences for stall/flush/counter corners.
module tb_id_ex_pipeline;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush;
  logic [31:0] data_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic [7:0]  ctrl_id;
  logic [3:0]  aluop_id;

  logic [31:0] Rs_data_EX, Rt_data_EX, Imm_EX, PC_plus4_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX, RegWr_EX;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX, RegDst_EX;
  logic        Load_Byte_control_EX, Store_Byte_control_EX, Hazard_Stall;
  logic [3:0]  ALUOp_EX;
  logic [7:0]  ctrl_ex;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] Bubble_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  assign ctrl_ex = {RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX,
                    ALUSrc_EX, RegDst_EX, Load_Byte_control_EX, Store_Byte_control_EX};

  id_ex_pipeline dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .Rs_data_ID(data_id), .Rt_data_ID(data_id ^ 32'h5A5A_0000),
    .Rs_ID(rs_id), .Rt_ID(rt_id), .Rd_ID(rd_id),
    .Imm_ID(data_id + 32'd1), .PC_plus4_ID(data_id + 32'd4),
    .RegWrite_ID(ctrl_id[7]), .MemRead_ID(ctrl_id[6]), .MemWrite_ID(ctrl_id[5]),
    .MemToReg_ID(ctrl_id[4]), .ALUSrc_ID(ctrl_id[3]), .RegDst_ID(ctrl_id[2]),
    .Load_Byte_control_ID(ctrl_id[1]), .Store_Byte_control_ID(ctrl_id[0]),
    .ALUOp_ID(aluop_id),
    .Rs_data_EX(Rs_data_EX), .Rt_data_EX(Rt_data_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
    .Rd_EX(Rd_EX), .Imm_EX(Imm_EX), .PC_plus4_EX(PC_plus4_EX),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .MemToReg_EX(MemToReg_EX), .ALUSrc_EX(ALUSrc_EX), .RegDst_EX(RegDst_EX),
    .Load_Byte_control_EX(Load_Byte_control_EX), .Store_Byte_control_EX(Store_Byte_control_EX),
    .ALUOp_EX(ALUOp_EX), .RegWr_EX(RegWr_EX),
`ifdef ID_EX_PERF_CNT_EN
    .Bubble_count(Bubble_count),
`endif
    .Hazard_Stall(Hazard_Stall)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic [4:0]  rs, rt, rd;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic [3:0]  aluop;
    logic        exp_hz;
    logic [7:0]  exp_ctrl;
    logic [3:0]  exp_aluop;
    logic [31:0] exp_data;
    logic [4:0]  exp_rs, exp_rt, exp_regwr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rst, input logic stall, input logic flush,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] data, input logic [7:0] ctrl, input logic [3:0] aluop,
                              input logic exp_hz, input logic [7:0] exp_ctrl, input logic [3:0] exp_aluop,
                              input logic [31:0] exp_data, input logic [4:0] exp_rs,
                              input logic [4:0] exp_rt, input logic [4:0] exp_regwr);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush;
    v.rs = rs; v.rt = rt; v.rd = rd; v.data = data; v.ctrl = ctrl; v.aluop = aluop;
    v.exp_hz = exp_hz; v.exp_ctrl = exp_ctrl; v.exp_aluop = exp_aluop; v.exp_data = exp_data;
    v.exp_rs = exp_rs; v.exp_rt = exp_rt; v.exp_regwr = exp_regwr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] data, input logic [7:0] ctrl, input logic [3:0] aluop);
    rs_id = rs; rt_id = rt; rd_id = rd; data_id = data; ctrl_id = ctrl; aluop_id = aluop;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // ctrl bits: {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,LB,SB}; D8 = lw, 84 = R-type
    vecs[0]  = mk(1,0,0, 31,31,31, 32'hFFFF_FFFF, 8'hFF, 4'hF, 0, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[1]  = mk(0,0,0,  3, 8,19, 32'h0A12,      8'h84, 4'h0, 0, 8'h84,4'h0, 32'h0A12, 3, 8,19);
    vecs[2]  = mk(0,0,0,  1, 8, 0, 32'h100,       8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h100,  1, 8, 8);
    vecs[3]  = mk(0,0,0,  8, 9,10, 32'hBAD,       8'h84, 4'h1, 1, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[4]  = mk(0,0,0,  8, 9,10, 32'h1234,      8'h84, 4'h1, 0, 8'h84,4'h1, 32'h1234, 8, 9,10);
    vecs[5]  = mk(0,0,0,  2, 0, 0, 32'h55,        8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h55,   2, 0, 0);
    vecs[6]  = mk(0,0,0,  0, 0, 5, 32'h66,        8'h84, 4'h3, 0, 8'h84,4'h3, 32'h66,   0, 0, 5);
    vecs[7]  = mk(0,0,0,  1, 7, 0, 32'h77,        8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h77,   1, 7, 7);
    vecs[8]  = mk(0,0,0,  7, 7,12, 32'h88,        8'h84, 4'h1, 1, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[9]  = mk(0,0,0,  7, 7,12, 32'h88,        8'h84, 4'h1, 0, 8'h84,4'h1, 32'h88,   7, 7,12);
    vecs[10] = mk(0,1,0,  4, 4, 4, 32'h99,        8'h20, 4'h5, 0, 8'h84,4'h1, 32'h88,   7, 7,12);
    vecs[11] = mk(0,1,0,  4, 4, 4, 32'h99,        8'h20, 4'h5, 0, 8'h84,4'h1, 32'h88,   7, 7,12);
    vecs[12] = mk(0,1,1,  4, 4, 4, 32'h99,        8'h20, 4'h5, 0, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[13] = mk(0,0,0,  1, 6, 0, 32'h13,        8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h13,   1, 6, 6);
    vecs[14] = mk(0,0,1,  6, 1, 2, 32'h14,        8'h84, 4'h1, 0, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[15] = mk(0,0,0,  1, 6, 0, 32'h15,        8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h15,   1, 6, 6);
    vecs[16] = mk(0,1,0,  6, 1, 2, 32'h16,        8'h84, 4'h1, 0, 8'hD8,4'h2, 32'h15,   1, 6, 6);
    vecs[17] = mk(1,0,0,  6, 1, 2, 32'h17,        8'h84, 4'h1, 1, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[18] = mk(0,0,0,  6, 2, 3, 32'h18,        8'h84, 4'h1, 0, 8'h84,4'h1, 32'h18,   6, 2, 3);
    vecs[19] = mk(0,0,0,  1, 5, 0, 32'h19,        8'hD8, 4'h2, 0, 8'hD8,4'h2, 32'h19,   1, 5, 5);
    vecs[20] = mk(0,0,0,  3, 5, 4, 32'h20,        8'h84, 4'h1, 1, 8'h00,4'h0, 32'h0,    0, 0, 0);
    vecs[21] = mk(0,0,0,  3, 5, 4, 32'h21,        8'h84, 4'h1, 0, 8'h84,4'h1, 32'h21,   3, 5, 4);

    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 32'd0, 8'h00, 4'h0);
    tick();

    for (int i = 0; i < 22; i++) begin
      Rst = vecs[i].rst; Stall = vecs[i].stall; Flush = vecs[i].flush;
      set_id(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].data, vecs[i].ctrl, vecs[i].aluop);
      @(negedge Clk);
      chk($sformatf("v%0d hazard_stall", i), {31'd0, Hazard_Stall}, {31'd0, vecs[i].exp_hz});
      tick();
      chk($sformatf("v%0d ctrl", i),     {24'd0, ctrl_ex},   {24'd0, vecs[i].exp_ctrl});
      chk($sformatf("v%0d aluop", i),    {28'd0, ALUOp_EX},  {28'd0, vecs[i].exp_aluop});
      chk($sformatf("v%0d rs_data", i),  Rs_data_EX,         vecs[i].exp_data);
      chk($sformatf("v%0d rt_data", i),  Rt_data_EX,
          (vecs[i].exp_ctrl == 8'h00) ? 32'd0 : (vecs[i].exp_data ^ 32'h5A5A_0000));
      chk($sformatf("v%0d imm", i),      Imm_EX,
          (vecs[i].exp_ctrl == 8'h00) ? 32'd0 : (vecs[i].exp_data + 32'd1));
      chk($sformatf("v%0d pc4", i),      PC_plus4_EX,
          (vecs[i].exp_ctrl == 8'h00) ? 32'd0 : (vecs[i].exp_data + 32'd4));
      chk($sformatf("v%0d rs", i),       {27'd0, Rs_EX},     {27'd0, vecs[i].exp_rs});
      chk($sformatf("v%0d rt", i),       {27'd0, Rt_EX},     {27'd0, vecs[i].exp_rt});
      chk($sformatf("v%0d regwr", i),    {27'd0, RegWr_EX},  {27'd0, vecs[i].exp_regwr});
    end

    // Hazard arriving while stalled, then released; then two flushes and a stall cycle.
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 32'd0, 8'h00, 4'h0);
    tick();
    Rst = 1'b0;
    set_id(5'd1, 5'd8, 5'd0, 32'hA0, 8'hD8, 4'h2);
    tick();
    set_id(5'd8, 5'd3, 5'd4, 32'hA1, 8'h84, 4'h1);
    Stall = 1'b1;
    @(negedge Clk);
    chk("seq stalled_hazard_masked", {31'd0, Hazard_Stall}, 32'd0);
    tick();
    chk("seq stall_holds_load", {24'd0, ctrl_ex}, 32'hD8);
    Stall = 1'b0;
    @(negedge Clk);
    chk("seq hazard_after_release", {31'd0, Hazard_Stall}, 32'd1);
    tick();
    chk("seq hazard_bubble", {24'd0, ctrl_ex}, 32'd0);
    @(negedge Clk);
    chk("seq hazard_drops", {31'd0, Hazard_Stall}, 32'd0);
    tick();
    chk("seq held_instr_loaded", {27'd0, RegWr_EX}, 32'd4);
    chk("seq held_instr_data", Rs_data_EX, 32'hA1);
    Flush = 1'b1;
    tick();
    tick();
    chk("seq flush_bubble", {24'd0, ctrl_ex}, 32'd0);
    Flush = 1'b0; Stall = 1'b1;
    tick();
    chk("seq stall_after_flush", {24'd0, ctrl_ex}, 32'd0);
    Stall = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    chk("seq bubble_count", Bubble_count, 32'd3);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("seq bubble_count_reset", Bubble_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
